// File: rtl/ssdisplay_scan_decoder_if.sv
// Display-side signal bundle for the scan decoder. The master drives the
// multiplexed anode/segment lines; the slave (decoder) returns the digits.
interface ssdisplay_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        stale;

  modport master (
    output an, seg,
    input  bcd_out, digit_err, frame_valid, stale
  );

  modport slave (
    input  an, seg,
    output bcd_out, digit_err, frame_valid, stale
  );
endinterface

// File: rtl/ssdisplay_scan_decoder.sv
// Snoops the anode/segment drive of a 4-digit multiplexed 7-segment display
// and reconstructs the displayed digits. A digit is accepted only after its
// {an,seg} pattern has been stable for STABLE_CYC consecutive samples.
module ssdisplay_scan_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  ssdisplay_scan_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    STABLE_LIM = 8'(STABLE_CYC);
  localparam logic [TW-1:0] TO_LIM     = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

  // Segment pattern -> {error, nibble}; blank shows as F without error.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = {1'b0, 4'h0};
      7'b1001111: r = {1'b0, 4'h1};
      7'b0010010: r = {1'b0, 4'h2};
      7'b0000110: r = {1'b0, 4'h3};
      7'b1001100: r = {1'b0, 4'h4};
      7'b0100100: r = {1'b0, 4'h5};
      7'b0100000: r = {1'b0, 4'h6};
      7'b0001111: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0000100: r = {1'b0, 4'h9};
      7'b1111111: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'hE};
    endcase
    return r;
  endfunction

  // Exactly one anode low selects a digit; anything else is not a scan slot.
  function automatic logic anode_valid(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] anode_slot(input logic [3:0] a);
    logic [1:0] r;
    case (a)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [3:0]    an_reg, an_prev_reg;
  logic [6:0]    seg_reg, seg_prev_reg;
  state_t        state_reg, state_next;
  logic [7:0]    stab_reg, stab_next;
  logic [15:0]   bcd_reg;
  logic [3:0]    err_reg;
  logic [3:0]    mask_reg, mask_next;
  logic          fv_reg;
  logic [TW-1:0] to_reg;

  logic          wr;
  logic          same;
  logic          an_ok;
  logic [4:0]    dec;
  logic [1:0]    slot;

  assign same  = ({an_reg, seg_reg} == {an_prev_reg, seg_prev_reg});
  assign an_ok = anode_valid(an_reg);
  assign dec   = decode_seg(seg_reg);
  assign slot  = anode_slot(an_reg);

  // Input sampling stage plus one-deep history used for stability detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg       <= 4'b1111;
      seg_reg      <= 7'b1111111;
      an_prev_reg  <= 4'b1111;
      seg_prev_reg <= 7'b1111111;
    end else begin
      an_reg       <= bus.an;
      seg_reg      <= bus.seg;
      an_prev_reg  <= an_reg;
      seg_prev_reg <= seg_reg;
    end
  end

  // FSM state and stability counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      stab_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      stab_reg  <= stab_next;
    end
  end

  // Next-state logic: a write fires on the edge where the count reaches the limit.
  always_comb begin
    state_next = state_reg;
    stab_next  = stab_reg;
    wr         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (an_ok) begin
          state_next = SETTLE;
          stab_next  = 8'd1;
        end
      end
      SETTLE: begin
        if (!same) begin
          state_next = an_ok ? SETTLE : IDLE;
          stab_next  = an_ok ? 8'd1 : 8'd0;
        end else if (stab_reg + 8'd1 == STABLE_LIM) begin
          wr         = 1'b1;
          state_next = CAPTURED;
          stab_next  = 8'd0;
        end else begin
          stab_next  = stab_reg + 8'd1;
        end
      end
      CAPTURED: begin
        if (!same) begin
          state_next = an_ok ? SETTLE : IDLE;
          stab_next  = an_ok ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_next = IDLE;
        stab_next  = 8'd0;
      end
    endcase
  end

  // A full mask is cleared on the edge that raises frame_valid; a write on that
  // same edge lands in the freshly cleared mask.
  always_comb begin
    mask_next = (mask_reg == 4'hF) ? 4'h0 : mask_reg;
    if (wr) begin
      mask_next = mask_next | ~an_reg;
    end
  end

  // Digit storage, frame tracking and staleness timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg  <= 16'hFFFF;
      err_reg  <= 4'b0000;
      mask_reg <= 4'b0000;
      fv_reg   <= 1'b0;
      to_reg   <= '0;
    end else begin
      mask_reg <= mask_next;
      fv_reg   <= (mask_reg == 4'hF);
      if (wr) begin
        bcd_reg[{slot, 2'b00} +: 4] <= dec[3:0];
        err_reg[slot]               <= dec[4];
        to_reg                      <= '0;
      end else if (to_reg != TO_LIM) begin
        to_reg <= to_reg + 1'b1;
      end
    end
  end

  assign bus.bcd_out     = bcd_reg;
  assign bus.digit_err   = err_reg;
  assign bus.frame_valid = fv_reg;
  assign bus.stale       = (to_reg == TO_LIM);

endmodule

// File: tb/tb_ssdisplay_scan_decoder.sv
// Scoreboard bench: stimulus pushes expected output snapshots tagged with the
// clock count at which they are due; a negedge monitor pops and compares them.
module tb_ssdisplay_scan_decoder;

  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S1   = 7'b1001111;
  localparam logic [6:0] S2   = 7'b0010010;
  localparam logic [6:0] S3   = 7'b0000110;
  localparam logic [6:0] S4   = 7'b1001100;
  localparam logic [6:0] S5   = 7'b0100100;
  localparam logic [6:0] S6   = 7'b0100000;
  localparam logic [6:0] S7   = 7'b0001111;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0000100;
  localparam logic [6:0] SBL  = 7'b1111111;
  localparam logic [6:0] SBAD = 7'b1111110;

  typedef struct {
    string       name;
    int          due;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        st;
    logic        fv;
    int          fvn;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fv_seen = 0;
  exp_t sb_q[$];

  ssdisplay_scan_decoder_if bus();

  ssdisplay_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_abs(input int due, input string nm, input logic [15:0] b,
                            input logic [3:0] e, input logic s, input logic f, input int n);
    exp_t x;
    int   idx;
    x.name = nm; x.due = due; x.bcd = b; x.err = e; x.st = s; x.fv = f; x.fvn = n;
    idx = sb_q.size();
    while (idx > 0 && sb_q[idx-1].due > due) idx--;
    sb_q.insert(idx, x);
  endtask

  task automatic expect_at(input int k, input string nm, input logic [15:0] b,
                           input logic [3:0] e, input logic s, input logic f, input int n);
    expect_abs(cyc + k, nm, b, e, s, f, n);
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    bus.an  = a;
    bus.seg = s;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: count frame pulses, then compare every snapshot that has come due.
  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_valid === 1'b1) fv_seen++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.bcd_out !== e.bcd || bus.digit_err !== e.err || bus.stale !== e.st ||
          bus.frame_valid !== e.fv || fv_seen != e.fvn) begin
        n_bad++;
        $display("FAIL %s @%0d: got bcd=%h err=%b stale=%b fv=%b frames=%0d, want bcd=%h err=%b stale=%b fv=%b frames=%0d",
                 e.name, cyc, bus.bcd_out, bus.digit_err, bus.stale, bus.frame_valid, fv_seen,
                 e.bcd, e.err, e.st, e.fv, e.fvn);
      end else begin
        $display("check %s @%0d: bcd=%h err=%b stale=%b fv=%b frames=%0d ok",
                 e.name, cyc, bus.bcd_out, bus.digit_err, bus.stale, bus.frame_valid, fv_seen);
      end
    end
  end

  initial begin
    int d0;
    int dw;
    rst = 1'b1;
    drive(4'b1111, SBL);
    hold(3);
    rst = 1'b0;
    expect_at(1, "reset", 16'hFFFF, 4'b0000, 1'b0, 1'b0, 0);

    // Digit 0 = 2 appears on exactly the 5th edge.
    drive(4'b1110, S2);
    expect_at(4, "lat_before", 16'hFFFF, 4'b0000, 1'b0, 1'b0, 0);
    expect_at(5, "lat_write",  16'hFFF2, 4'b0000, 1'b0, 1'b0, 0);
    hold(8);

    // Too-short dwell then blank anode: nothing written.
    drive(4'b1101, S1);
    hold(3);
    drive(4'b1111, SBL);
    expect_at(6, "short_dwell", 16'hFFF2, 4'b0000, 1'b0, 1'b0, 0);
    hold(8);

    // Full scan 1,2,3,4; frame pulse one cycle after the digit 3 write.
    drive(4'b1110, S1);
    expect_at(5, "scan_d0", 16'hFFF1, 4'b0000, 1'b0, 1'b0, 0);
    hold(8);
    drive(4'b1101, S2);
    expect_at(5, "scan_d1", 16'hFF21, 4'b0000, 1'b0, 1'b0, 0);
    hold(8);
    drive(4'b1011, S3);
    expect_at(5, "scan_d2", 16'hF321, 4'b0000, 1'b0, 1'b0, 0);
    hold(8);
    drive(4'b0111, S4);
    expect_at(5, "scan_d3",    16'h4321, 4'b0000, 1'b0, 1'b0, 0);
    expect_at(6, "frame_hi",   16'h4321, 4'b0000, 1'b0, 1'b1, 1);
    expect_at(7, "frame_lo",   16'h4321, 4'b0000, 1'b0, 1'b0, 1);
    hold(8);

    // Illegal segment pattern then blank on digit 2.
    d0 = cyc;
    drive(4'b1011, SBAD);
    expect_at(5, "illegal", 16'h4E21, 4'b0100, 1'b0, 1'b0, 1);
    hold(6);
    drive(4'b1011, SBL);
    expect_at(5, "blank", 16'h4F21, 4'b0000, 1'b0, 1'b0, 1);
    dw = d0 + 11;
    hold(8);

    // Multi-zero anode: no write; then idle until stale at exactly 1024 cycles.
    drive(4'b1100, S8);
    expect_at(19, "multi_zero", 16'h4F21, 4'b0000, 1'b0, 1'b0, 1);
    hold(20);
    drive(4'b1111, SBL);
    expect_abs(dw + 1023, "stale_edge_lo", 16'h4F21, 4'b0000, 1'b0, 1'b0, 1);
    expect_abs(dw + 1024, "stale_edge_hi", 16'h4F21, 4'b0000, 1'b1, 1'b0, 1);
    hold(1024);
    drive(4'b1110, S4);
    expect_at(4, "stale_held",  16'h4F21, 4'b0000, 1'b1, 1'b0, 1);
    expect_at(5, "stale_clear", 16'h4F24, 4'b0000, 1'b0, 1'b0, 1);
    hold(8);

    // Reset on the 3rd cycle of a dwell discards it; dwell restarts afterwards.
    drive(4'b1101, S5);
    hold(2);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    expect_at(0 + 1, "rst_vals",    16'hFFFF, 4'b0000, 1'b0, 1'b0, 1);
    expect_at(2,     "rst_nowrite", 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1);
    expect_at(4,     "rst_before",  16'hFFFF, 4'b0000, 1'b0, 1'b0, 1);
    expect_at(5,     "rst_rewrite", 16'hFF5F, 4'b0000, 1'b0, 1'b0, 1);
    hold(8);

    // Complete a second frame from the post-reset mask.
    drive(4'b1110, S7);
    expect_at(5, "f2_d0", 16'hFF57, 4'b0000, 1'b0, 1'b0, 1);
    hold(8);
    drive(4'b1011, S6);
    expect_at(5, "f2_d2", 16'hF657, 4'b0000, 1'b0, 1'b0, 1);
    hold(8);
    drive(4'b0111, S0);
    expect_at(5, "f2_d3",    16'h0657, 4'b0000, 1'b0, 1'b0, 1);
    expect_at(6, "f2_frame", 16'h0657, 4'b0000, 1'b0, 1'b1, 2);
    hold(8);

    // Rewrites with the remaining digit codes; mask 0111 gives no pulse.
    drive(4'b1101, S8);
    expect_at(5, "rw_d1", 16'h0687, 4'b0000, 1'b0, 1'b0, 2);
    hold(8);
    drive(4'b1110, S9);
    expect_at(5, "rw_d0", 16'h0689, 4'b0000, 1'b0, 1'b0, 2);
    hold(8);
    drive(4'b1011, S3);
    expect_at(5, "rw_d2",  16'h0389, 4'b0000, 1'b0, 1'b0, 2);
    expect_at(12, "final", 16'h0389, 4'b0000, 1'b0, 1'b0, 2);
    hold(8);
    drive(4'b1111, SBL);

    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d snapshots still pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
